ahb2apb_bridge_param: RTL and testbench
=======================================

# ahb2apb_bridge_param

Parametrised AHB-Lite to APB synchronous bridge. It succeeds the fixed-function sync bridge with a build-time selectable APB2, APB3 or APB4 protocol mode, a configurable address width, and full PREADY/PSLVERR handling with a two-cycle AHB error response. It also generates PSTRB and PPROT. It sits between the AHB interconnect slave port and the APB peripheral decoder, and it runs on the AHB clock, qualified by pclken.

## Interface
- ADDRWIDTH, 16: width of haddr and paddr.
- APB_MODE, 4: protocol mode; legal values are 2, 3, 4.
- clk  in  1  HCLK; all logic is synchronous to the rising edge.
- rst  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select.
- haddr  in  ADDRWIDTH  AHB address.
- htrans  in  2  transfer type.
- hsize  in  3  transfer size.
- hprot  in  4  protection attributes.
- hwrite  in  1  1 = write.
- hready  in  1  bus ready from the interconnect.
- hwdata  in  32  write data, valid in the data phase.
- hreadyout  out  1  slave ready.
- hresp  out  1  1 = ERROR.
- hrdata  out  32  registered read data.
- pclken  in  1  APB clock enable; pclk edges coincide with clk edges where pclken = 1.
- apbactive  out  1  high while a transfer is in flight, for APB clock gating.
- paddr  out  ADDRWIDTH; psel  out  1; penable  out  1; pwrite  out  1; pwdata  out  32.
- prdata  in  32.
- pready  in  1; pslverr  in  1. Both are ignored when APB_MODE = 2, where pready is taken as 1 and pslverr as 0.
- pstrb  out  4; pprot  out  3. Both are driven 0 unless APB_MODE = 4.

## Operation
- A transfer is captured when hsel & htrans[1] & hready are all high. IDLE and BUSY transfers get a zero-wait OKAY response.
- On capture, the bridge registers haddr, hwrite, hsize and hprot.
- State machine transitions:
  - IDLE -> WAIT on capture.
  - WAIT -> SETUP when pclken = 1. pwdata is loaded from hwdata on this transition; the master holds hwdata while hreadyout = 0.
  - SETUP -> ACCESS when pclken = 1.
  - ACCESS -> IDLE when pclken & pready & !pslverr. For a read, hrdata is loaded from prdata on this edge.
  - ACCESS -> ERR1 when pclken & pready & pslverr.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> IDLE, or ERR2 -> WAIT if a new transfer is captured in ERR2.
- Output decode by state:
  - hreadyout = 1 in IDLE and ERR2, 0 otherwise.
  - hresp = 1 in ERR1 and ERR2.
  - psel = 1 in SETUP and ACCESS.
  - penable = 1 in ACCESS only.
  - apbactive = (state != IDLE).
- pstrb, for APB4 writes only (reads drive 0000):
  - byte: 0001 << haddr[1:0]
  - half: 0011 << {haddr[1], 0}
  - word: 1111
- pprot = {~hprot[0], 1'b1, hprot[1]}, i.e. instruction, non-secure, privileged.
- paddr, pwrite, pstrb and pprot stay stable from SETUP through ACCESS.

## Timing
- Reset values: state IDLE; hreadyout 1; hresp 0; hrdata 0; psel, penable, pwrite 0; paddr, pwdata, pstrb, pprot 0; apbactive 0.
- Reset mid-transfer drops psel and penable immediately, with no completion.
- With pclken = 1 and pready = 1:
  - Capture at edge E1, SETUP at E2, ACCESS at E3, complete at E4.
  - hreadyout is low from E1 to E4, giving 3 AHB wait states.
  - Read data appears on hrdata with hreadyout = 1 after E4.
- Each pclken = 0 cycle in WAIT, SETUP or ACCESS adds one wait state.
- Each pready = 0 sample in ACCESS (with pclken = 1) adds one pclk period.
- Error response: hresp is high for exactly 2 cycles; hreadyout is 0 in the first and 1 in the second.
- hrdata is not updated on writes or on errored reads.

## Structure
- Package ahb2apb_pkg holds:
  - the state enum (IDLE, WAIT, SETUP, ACCESS, ERR1, ERR2);
  - the HTRANS and HSIZE constants;
  - the APB_MODE constants (APB2, APB3, APB4);
  - the strobe function.
- Sub-module apb_strb_gen generates pstrb from hsize, haddr[1:0] and hwrite.
- APB_MODE selects its logic via generate blocks.

## Test plan
- Word write to 0x0040, data 0xDEADBEEF, pclken = 1, pready = 1 -> psel high at E2, penable high at E3, pwdata = 0xDEADBEEF, pstrb = 1111, hreadyout low for exactly 3 cycles.
- Byte write to 0x0043 (APB4) -> pstrb = 1000. Halfword write to 0x0042 -> pstrb = 1100. Read to 0x0043 -> pstrb = 0000.
- Read from 0x0010 with prdata = 0x12345678 and pready low for 2 pclk -> 5 wait states, hrdata = 0x12345678, hresp = 0.
- pslverr = 1 on a write completion -> ERR1 (hreadyout = 0, hresp = 1), then ERR2 (hreadyout = 1, hresp = 1). A back-to-back read captured in ERR2 proceeds normally.
- pclken toggling 1-0-1-0 with a read -> each SETUP/ACCESS lasts 2 clk and apbactive stays high throughout. In APB_MODE = 2, a pslverr = 1 input is ignored.
- rst asserted in ACCESS -> psel, penable and apbactive go 0 asynchronously and hreadyout goes 1. A following read completes normally.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge: FSM states,
// AHB transfer/size encodings, APB protocol modes and the byte-strobe helper.
package ahb2apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int APB2 = 2;
    localparam int APB3 = 3;
    localparam int APB4 = 4;

    // Byte-lane mask for a transfer; sizes wider than a word cover all lanes.
    function automatic logic [3:0] strb_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << addr_lo;
            HSIZE_HALF: mask = 4'b0011 << {addr_lo[1], 1'b0};
            default:    mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb2apb_bridge_param_strb_gen.sv
// Write strobe generator: byte-lane enables from transfer size and address
// low bits, forced to zero for reads.
module apb_strb_gen
    import ahb2apb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    input  logic       hwrite,
    output logic [3:0] pstrb
);

    logic [3:0] lane_mask;

    assign lane_mask = strb_mask(hsize, addr_lo);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign pstrb[gi] = hwrite & lane_mask[gi];
    end

endmodule

// File: rtl/ahb2apb_bridge_param.sv
// AHB-Lite to APB bridge running on HCLK, stepping the APB side on pclken,
// with build-time APB2/APB3/APB4 selection and a two-cycle AHB error response.
module ahb2apb_bridge_param
    import ahb2apb_pkg::*;
#(
    parameter int ADDRWIDTH = 16,
    parameter int APB_MODE  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hsel,
    input  logic [ADDRWIDTH-1:0] haddr,
    input  logic [1:0]           htrans,
    input  logic [2:0]           hsize,
    input  logic [3:0]           hprot,
    input  logic                 hwrite,
    input  logic                 hready,
    input  logic [31:0]          hwdata,
    output logic                 hreadyout,
    output logic                 hresp,
    output logic [31:0]          hrdata,
    input  logic                 pclken,
    output logic                 apbactive,
    output logic [ADDRWIDTH-1:0] paddr,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [31:0]          pwdata,
    input  logic [31:0]          prdata,
    input  logic                 pready,
    input  logic                 pslverr,
    output logic [3:0]           pstrb,
    output logic [2:0]           pprot
);

    state_t               state_reg, state_next;
    logic                 start;
    logic                 pready_eff, pslverr_eff;
    logic [3:0]           strb_raw;
    logic [3:0]           pstrb_reg;
    logic [2:0]           pprot_reg;
    logic                 hreadyout_reg, hresp_reg, psel_reg, penable_reg;
    logic                 apbactive_reg, pwrite_reg;
    logic [ADDRWIDTH-1:0] paddr_reg;
    logic [31:0]          pwdata_reg, hrdata_reg;
    logic                 unused_ahb;

    assign unused_ahb = ^{hprot[3:2], htrans[0]};

    // New transfers are only accepted while the bridge is presenting hreadyout.
    assign start = hsel & htrans[1] & hready & ((state_reg == IDLE) || (state_reg == ERR2));

    generate
        if (APB_MODE == APB2) begin : g_apb2_resp
            logic unused_resp;
            assign unused_resp = pready ^ pslverr;
            assign pready_eff  = 1'b1;
            assign pslverr_eff = 1'b0;
        end else begin : g_apb34_resp
            assign pready_eff  = pready;
            assign pslverr_eff = pslverr;
        end

        if (APB_MODE == APB4) begin : g_apb4_side
            assign pstrb = pstrb_reg;
            assign pprot = pprot_reg;
        end else begin : g_legacy_side
            logic unused_side;
            assign unused_side = ^{pstrb_reg, pprot_reg};
            assign pstrb = 4'b0000;
            assign pprot = 3'b000;
        end
    endgenerate

    apb_strb_gen u_strb_gen (
        .hsize   (hsize),
        .addr_lo (haddr[1:0]),
        .hwrite  (hwrite),
        .pstrb   (strb_raw)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = WAIT;
            WAIT:    if (pclken) state_next = SETUP;
            SETUP:   if (pclken) state_next = ACCESS;
            ACCESS:  if (pclken && pready_eff) state_next = pslverr_eff ? ERR1 : IDLE;
            ERR1:    state_next = ERR2;
            ERR2:    state_next = start ? WAIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 1'b0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            apbactive_reg <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pstrb_reg     <= 4'b0000;
            pprot_reg     <= 3'b000;
            pwdata_reg    <= 32'h0;
            hrdata_reg    <= 32'h0;
        end else begin
            state_reg     <= state_next;
            hreadyout_reg <= (state_next == IDLE) || (state_next == ERR2);
            hresp_reg     <= (state_next == ERR1) || (state_next == ERR2);
            psel_reg      <= (state_next == SETUP) || (state_next == ACCESS);
            penable_reg   <= (state_next == ACCESS);
            apbactive_reg <= (state_next != IDLE);

            if (start) begin
                paddr_reg  <= haddr;
                pwrite_reg <= hwrite;
                pstrb_reg  <= strb_raw;
                pprot_reg  <= {~hprot[0], 1'b1, hprot[1]};
            end

            if ((state_reg == WAIT) && pclken) begin
                pwdata_reg <= hwdata;
            end

            if ((state_reg == ACCESS) && pclken && pready_eff && !pslverr_eff && !pwrite_reg) begin
                hrdata_reg <= prdata;
            end
        end
    end

    assign hreadyout = hreadyout_reg;
    assign hresp     = hresp_reg;
    assign hrdata    = hrdata_reg;
    assign psel      = psel_reg;
    assign penable   = penable_reg;
    assign apbactive = apbactive_reg;
    assign pwrite    = pwrite_reg;
    assign paddr     = paddr_reg;
    assign pwdata    = pwdata_reg;

endmodule

// File: tb/tb_ahb2apb_bridge_param.sv
// Self-checking bench: a transaction-level timing model derived from the
// pclken/pready sequences predicts every output cycle; an APB4 and an APB2 instance.
module tb_ahb2apb_bridge_param;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        hsel, hwrite, hready, pclken, pready, pslverr;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata, prdata;

    logic        hreadyout_a, hresp_a, apbactive_a, psel_a, penable_a, pwrite_a;
    logic [31:0] hrdata_a, pwdata_a;
    logic [15:0] paddr_a;
    logic [3:0]  pstrb_a;
    logic [2:0]  pprot_a;
    logic        hreadyout_b, hresp_b, apbactive_b, psel_b, penable_b, pwrite_b;
    logic [31:0] hrdata_b, pwdata_b;
    logic [15:0] paddr_b;
    logic [3:0]  pstrb_b;
    logic [2:0]  pprot_b;

    logic        sel2;
    logic        o_hreadyout, o_hresp, o_apbactive, o_psel, o_penable, o_pwrite;
    logic [31:0] o_hrdata, o_pwdata;
    logic [15:0] o_paddr;
    logic [3:0]  o_pstrb;
    logic [2:0]  o_pprot;

    logic        e_hreadyout, e_hresp, e_apbactive, e_psel, e_penable, e_pwrite;
    logic [31:0] e_hrdata, e_pwdata;
    logic [15:0] e_paddr;
    logic [3:0]  e_pstrb;
    logic [2:0]  e_pprot;

    int checks = 0;
    int errors = 0;
    int low_cnt = 0;
    int mode = 4;
    logic chk_en = 1'b0;
    bit pck[64];
    bit prdy[64];

    always #5 clk = ~clk;

    ahb2apb_bridge_param #(.ADDRWIDTH(16), .APB_MODE(4)) dut_a (
        .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize),
        .hprot(hprot), .hwrite(hwrite), .hready(hready), .hwdata(hwdata),
        .hreadyout(hreadyout_a), .hresp(hresp_a), .hrdata(hrdata_a), .pclken(pclken),
        .apbactive(apbactive_a), .paddr(paddr_a), .psel(psel_a), .penable(penable_a),
        .pwrite(pwrite_a), .pwdata(pwdata_a), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .pstrb(pstrb_a), .pprot(pprot_a)
    );

    ahb2apb_bridge_param #(.ADDRWIDTH(16), .APB_MODE(2)) dut_b (
        .clk(clk), .rst(rst2), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize),
        .hprot(hprot), .hwrite(hwrite), .hready(hready), .hwdata(hwdata),
        .hreadyout(hreadyout_b), .hresp(hresp_b), .hrdata(hrdata_b), .pclken(pclken),
        .apbactive(apbactive_b), .paddr(paddr_b), .psel(psel_b), .penable(penable_b),
        .pwrite(pwrite_b), .pwdata(pwdata_b), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .pstrb(pstrb_b), .pprot(pprot_b)
    );

    assign o_hreadyout = sel2 ? hreadyout_b : hreadyout_a;
    assign o_hresp     = sel2 ? hresp_b     : hresp_a;
    assign o_apbactive = sel2 ? apbactive_b : apbactive_a;
    assign o_psel      = sel2 ? psel_b      : psel_a;
    assign o_penable   = sel2 ? penable_b   : penable_a;
    assign o_pwrite    = sel2 ? pwrite_b    : pwrite_a;
    assign o_hrdata    = sel2 ? hrdata_b    : hrdata_a;
    assign o_pwdata    = sel2 ? pwdata_b    : pwdata_a;
    assign o_paddr     = sel2 ? paddr_b     : paddr_a;
    assign o_pstrb     = sel2 ? pstrb_b     : pstrb_a;
    assign o_pprot     = sel2 ? pprot_b     : pprot_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hreadyout", 32'(o_hreadyout), 32'(e_hreadyout));
            chk("hresp",     32'(o_hresp),     32'(e_hresp));
            chk("apbactive", 32'(o_apbactive), 32'(e_apbactive));
            chk("psel",      32'(o_psel),      32'(e_psel));
            chk("penable",   32'(o_penable),   32'(e_penable));
            chk("hrdata",    o_hrdata,         e_hrdata);
            if (e_psel) begin
                chk("paddr",  32'(o_paddr),  32'(e_paddr));
                chk("pwrite", 32'(o_pwrite), 32'(e_pwrite));
                chk("pwdata", o_pwdata,      e_pwdata);
                chk("pstrb",  32'(o_pstrb),  32'(e_pstrb));
                chk("pprot",  32'(o_pprot),  32'(e_pprot));
            end
            if (!o_hreadyout) low_cnt++;
        end
    end

    task automatic set_idle_exp();
        e_hreadyout = 1'b1; e_hresp = 1'b0; e_apbactive = 1'b0;
        e_psel = 1'b0; e_penable = 1'b0;
    endtask

    task automatic idle_cycle();
        hsel = 1'b0; htrans = 2'b00;
        @(posedge clk); #1;
        pclken = 1'($urandom_range(0, 1));
        pready = 1'($urandom_range(0, 1));
        set_idle_exp();
    endtask

    task automatic pat_ones();
        for (int c = 0; c < 64; c++) begin pck[c] = 1'b1; prdy[c] = 1'b1; end
    endtask

    task automatic pat_rand();
        for (int c = 0; c < 64; c++) begin
            pck[c]  = ($urandom_range(0, 3) != 0);
            prdy[c] = ($urandom_range(0, 2) != 0);
        end
    endtask

    // Entered #1 after an edge with the bridge ready; returns #1 after the
    // completion edge (IDLE) or the ERR2 entry edge.
    task automatic xfer(input logic [15:0] addr, input logic wr, input logic [2:0] sz,
                        input logic [3:0] prot, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic err_in);
        int s, a, d;
        logic err;
        logic [3:0] strb;
        logic [2:0] prot_e;
        for (int c = 56; c < 64; c++) begin pck[c] = 1'b1; prdy[c] = 1'b1; end
        s = -1; a = -1; d = -1;
        for (int c = 0; c < 64; c++) begin
            if (s < 0) begin
                if (pck[c]) s = c;
            end else if (a < 0) begin
                if (pck[c]) a = c;
            end else if (d < 0) begin
                if (pck[c] && (mode == 2 || prdy[c])) d = c;
            end
        end
        err = err_in && (mode != 2);
        strb = 4'b0000;
        prot_e = 3'b000;
        if (mode == 4) begin
            if (wr) begin
                case (sz)
                    3'd0:    strb = 4'b0001 << addr[1:0];
                    3'd1:    strb = addr[1] ? 4'b1100 : 4'b0011;
                    default: strb = 4'b1111;
                endcase
            end
            prot_e = {~prot[0], 1'b1, prot[1]};
        end

        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = sz; hprot = prot; hready = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'($urandom_range(0, 1)); haddr = 16'($urandom);
        hwrite = 1'($urandom_range(0, 1)); hsize = 3'($urandom_range(0, 2)); hprot = 4'($urandom);
        hwdata = wdata; prdata = rdata; pslverr = err_in;
        e_paddr = addr; e_pwrite = wr; e_pwdata = wdata; e_pstrb = strb; e_pprot = prot_e;
        for (int c = 0; c <= d; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            pclken = pck[c]; pready = prdy[c];
            e_hreadyout = 1'b0; e_hresp = 1'b0; e_apbactive = 1'b1;
            e_psel = (c > s); e_penable = (c > a);
        end
        @(posedge clk); #1;
        pclken = 1'($urandom_range(0, 1)); pready = 1'($urandom_range(0, 1));
        e_psel = 1'b0; e_penable = 1'b0;
        if (err) begin
            e_hreadyout = 1'b0; e_hresp = 1'b1; e_apbactive = 1'b1;
            @(posedge clk); #1;
            e_hreadyout = 1'b1; e_hresp = 1'b1; e_apbactive = 1'b1;
        end else begin
            set_idle_exp();
            if (!wr) e_hrdata = rdata;
        end
    endtask

    task automatic rand_xfer();
        logic wr;
        logic [2:0] sz;
        wr = 1'($urandom_range(0, 1));
        sz = 3'($urandom_range(0, 2));
        pat_rand();
        xfer(16'($urandom), wr, sz, 4'($urandom), $urandom, $urandom, ($urandom_range(0, 4) == 0));
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; sel2 = 1'b0;
        hsel = 1'b0; haddr = 16'h0; htrans = 2'b00; hsize = 3'b000; hprot = 4'h0;
        hwrite = 1'b0; hready = 1'b1; hwdata = 32'h0; pclken = 1'b1; prdata = 32'h0;
        pready = 1'b1; pslverr = 1'b0;
        e_hrdata = 32'h0; e_paddr = 16'h0; e_pwrite = 1'b0; e_pwdata = 32'h0;
        e_pstrb = 4'h0; e_pprot = 3'h0;
        set_idle_exp();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hreadyout", 32'(hreadyout_a), 32'd1);
        chk("rst_hresp",     32'(hresp_a),     32'd0);
        chk("rst_hrdata",    hrdata_a,         32'd0);
        chk("rst_psel",      32'(psel_a),      32'd0);
        chk("rst_penable",   32'(penable_a),   32'd0);
        chk("rst_pwrite",    32'(pwrite_a),    32'd0);
        chk("rst_paddr",     32'(paddr_a),     32'd0);
        chk("rst_pwdata",    pwdata_a,         32'd0);
        chk("rst_pstrb",     32'(pstrb_a),     32'd0);
        chk("rst_pprot",     32'(pprot_a),     32'd0);
        chk("rst_apbactive", 32'(apbactive_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        idle_cycle();

        pat_ones(); low_cnt = 0;
        xfer(16'h0040, 1'b1, 3'd2, 4'h3, 32'hDEADBEEF, 32'h0BAD0BAD, 1'b0);
        chk("word_wait_states", 32'(low_cnt), 32'd3);
        chk("word_pwdata", pwdata_a, 32'hDEADBEEF);
        chk("word_pstrb", 32'(pstrb_a), 32'hF);
        chk("word_pprot", 32'(pprot_a), 32'b011);
        idle_cycle();

        pat_ones();
        xfer(16'h0043, 1'b1, 3'd0, 4'h0, 32'h11223344, 32'h0, 1'b0);
        chk("byte_pstrb", 32'(pstrb_a), 32'b1000);
        xfer(16'h0042, 1'b1, 3'd1, 4'h1, 32'h55667788, 32'h0, 1'b0);
        chk("half_pstrb", 32'(pstrb_a), 32'b1100);
        xfer(16'h0043, 1'b0, 3'd0, 4'h2, 32'h0, 32'hCAFEF00D, 1'b0);
        chk("read_pstrb", 32'(pstrb_a), 32'b0000);
        chk("read_pprot", 32'(pprot_a), 32'b111);
        idle_cycle();

        pat_ones(); prdy[2] = 1'b0; prdy[3] = 1'b0; low_cnt = 0;
        xfer(16'h0010, 1'b0, 3'd2, 4'h0, 32'h0, 32'h12345678, 1'b0);
        chk("slow_read_wait_states", 32'(low_cnt), 32'd5);
        chk("slow_read_hrdata", hrdata_a, 32'h12345678);
        chk("slow_read_hresp", 32'(hresp_a), 32'd0);
        idle_cycle();

        pat_ones(); low_cnt = 0;
        xfer(16'h0080, 1'b1, 3'd2, 4'h0, 32'hA5A5A5A5, 32'hFFFF0000, 1'b1);
        chk("err_low_cycles", 32'(low_cnt), 32'd4);
        chk("err2_hresp", 32'(hresp_a), 32'd1);
        chk("err2_hreadyout", 32'(hreadyout_a), 32'd1);
        pat_ones();
        xfer(16'h0084, 1'b0, 3'd2, 4'h0, 32'h0, 32'h600DF00D, 1'b0);
        chk("b2b_read_hrdata", hrdata_a, 32'h600DF00D);
        idle_cycle();

        for (int c = 0; c < 64; c++) begin pck[c] = (c % 2 == 0); prdy[c] = 1'b1; end
        low_cnt = 0;
        xfer(16'h0100, 1'b0, 3'd2, 4'h0, 32'h0, 32'h89ABCDEF, 1'b0);
        chk("toggle_wait_states", 32'(low_cnt), 32'd5);
        idle_cycle();

        for (int t = 0; t < 40; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle();
            rand_xfer();
        end
        idle_cycle();
        idle_cycle();

        chk_en = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = 16'h0200; hwrite = 1'b0; hsize = 3'd2; hprot = 4'h0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; pclken = 1'b1; pready = 1'b0; pslverr = 1'b0; prdata = 32'h77777777;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_psel", 32'(psel_a), 32'd1);
        chk("pre_rst_penable", 32'(penable_a), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_psel", 32'(psel_a), 32'd0);
        chk("async_rst_penable", 32'(penable_a), 32'd0);
        chk("async_rst_apbactive", 32'(apbactive_a), 32'd0);
        chk("async_rst_hreadyout", 32'(hreadyout_a), 32'd1);
        #1;
        rst = 1'b0;
        e_hrdata = 32'h0;
        set_idle_exp();
        pready = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        pat_ones();
        xfer(16'h0204, 1'b0, 3'd2, 4'h0, 32'h0, 32'h13579BDF, 1'b0);
        chk("post_rst_hrdata", hrdata_a, 32'h13579BDF);
        idle_cycle();

        chk_en = 1'b0;
        rst = 1'b1;
        rst2 = 1'b0;
        sel2 = 1'b1;
        mode = 2;
        e_hrdata = 32'h0;
        set_idle_exp();
        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int c = 0; c < 64; c++) begin pck[c] = 1'b1; prdy[c] = 1'b0; end
        low_cnt = 0;
        xfer(16'h0300, 1'b0, 3'd2, 4'h0, 32'h0, 32'h2468ACE0, 1'b1);
        chk("apb2_wait_states", 32'(low_cnt), 32'd3);
        chk("apb2_hrdata", hrdata_b, 32'h2468ACE0);
        chk("apb2_hresp", 32'(hresp_b), 32'd0);
        idle_cycle();
        pat_ones();
        xfer(16'h0303, 1'b1, 3'd0, 4'h0, 32'h000000FF, 32'h0, 1'b0);
        chk("apb2_pstrb", 32'(pstrb_b), 32'd0);
        for (int t = 0; t < 10; t++) begin
            idle_cycle();
            rand_xfer();
        end
        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
